// File: rtl/hdmi_frame_sender.sv
// rtl/hdmi_frame_sender.sv - raster timing generator that pulls a ready/valid pixel stream
// and drives registered sync/DE/RGB towards the TMDS encoder.
module hdmi_frame_sender #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SENDER_GO,
  output logic        SENDER_RUN,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_SOF,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        VID_HS,
  output logic        VID_VS,
  output logic        VID_DE,
  output logic [23:0] VID_RGB,
  output logic        UNDERFLOW,
  output logic        SOF_ERR
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            uf_q, uf_d;
  logic            sof_err_q, sof_err_d;

  logic running, h_last, v_last, active, hs_region, vs_region;
  logic accept, at_origin, start;

  assign running   = (state_q == S_RUN);
  assign h_last    = (h_q == H_LAST);
  assign v_last    = (v_q == V_LAST);
  assign active    = running && (h_q < H_ACT_L) && (v_q < V_ACT_L);
  assign hs_region = running && (h_q >= H_SS) && (h_q < H_SE);
  assign vs_region = running && (v_q >= V_SS) && (v_q < V_SE);
  assign accept    = active && PIX_VALID;
  assign at_origin = (h_q == '0) && (v_q == '0);
  assign start     = (state_q == S_IDLE) && SENDER_GO;

  // GO is only looked at on the last pixel of a frame, so frames are never truncated.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (SENDER_GO) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (h_last) begin
          h_d = '0;
          if (v_last) begin
            v_d = '0;
            if (!SENDER_GO) begin
              state_d = S_IDLE;
            end
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // Sticky flags: the clear on a fresh start is applied first so a same-cycle set wins.
  always_comb begin
    hs_d  = hs_region ? HS_POL : ~HS_POL;
    vs_d  = vs_region ? VS_POL : ~VS_POL;
    de_d  = active;
    rgb_d = accept ? PIX_DATA : 24'h0;

    uf_d = start ? 1'b0 : uf_q;
    if (active && !PIX_VALID) begin
      uf_d = 1'b1;
    end

    sof_err_d = start ? 1'b0 : sof_err_q;
    if (accept && (PIX_SOF != at_origin)) begin
      sof_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      rgb_q     <= 24'h0;
      uf_q      <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      rgb_q     <= rgb_d;
      uf_q      <= uf_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign SENDER_RUN = running;
  assign PIX_READY  = active;
  assign VID_HS     = hs_q;
  assign VID_VS     = vs_q;
  assign VID_DE     = de_q;
  assign VID_RGB    = rgb_q;
  assign UNDERFLOW  = uf_q;
  assign SOF_ERR    = sof_err_q;

endmodule
